// File: rtl/lsu_sequencer.sv
// Load/store sequencer: turns one decoded memory access into one or two handshaked
// word transfers, with lane shifting, byte enables and load-data extension.
module lsu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic        done_q, done_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        store_q, store_d, uns_q, uns_d, split_q, split_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [3:0]  be1_q, be1_d;
  logic [31:0] wdata1_q, wdata1_d, lo_q, lo_d;

  logic        req_valid;
  logic [2:0]  req_nbytes;
  logic [7:0]  req_mask;
  logic [63:0] req_shift, req_wdata;

  assign req_valid = start && (mem_read || mem_write);

  function automatic logic [31:0] load_extend(input logic [63:0] beats, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] w;
    w = 32'(beats >> {off, 3'b000});
    case (size)
      2'b00:   load_extend = {{24{~uns & w[7]}}, w[7:0]};
      2'b01:   load_extend = {{16{~uns & w[15]}}, w[15:0]};
      default: load_extend = w;
    endcase
  endfunction

  // Lanes 0-3 of the 8-lane view belong to beat 0, lanes 4-7 to beat 1.
  always_comb begin
    case (mem_size)
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
    req_mask  = ((8'd1 << req_nbytes) - 8'd1) << addr[1:0];
    req_shift = {32'b0, wdata} << {addr[1:0], 3'b000};
    for (int i = 0; i < 8; i++) begin
      req_wdata[8*i +: 8] = req_mask[i] ? req_shift[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      store_q     <= 1'b0;
      uns_q       <= 1'b0;
      split_q     <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      be1_q       <= '0;
      wdata1_q    <= '0;
      lo_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      store_q     <= store_d;
      uns_q       <= uns_d;
      split_q     <= split_d;
      size_q      <= size_d;
      off_q       <= off_d;
      be1_q       <= be1_d;
      wdata1_q    <= wdata1_d;
      lo_q        <= lo_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (mem_size == 2'b11) ? DONE : BEAT0;
      BEAT0:   if (bus_ready) state_d = split_q ? BEAT1 : DONE;
      BEAT1:   if (bus_ready) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    store_d     = store_q;
    uns_d       = uns_q;
    split_d     = split_q;
    size_d      = size_q;
    off_d       = off_q;
    be1_d       = be1_q;
    wdata1_d    = wdata1_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (req_valid && mem_size == 2'b11) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (req_valid) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = req_mask[3:0];
          bus_wdata_d = req_wdata[31:0];
          be1_d       = req_mask[7:4];
          wdata1_d    = req_wdata[63:32];
          split_d     = |req_mask[7:4];
          store_d     = mem_write;
          uns_d       = mem_unsigned;
          size_d      = mem_size;
          off_d       = addr[1:0];
        end
      end
      BEAT0: begin
        if (bus_ready) begin
          lo_d = bus_rdata;
          if (split_q) begin
            bus_addr_d  = bus_addr_q + 32'd4;
            bus_be_d    = be1_q;
            bus_wdata_d = wdata1_q;
          end else begin
            {bus_req_d, bus_we_d, bus_addr_d, bus_be_d, bus_wdata_d} = '0;
            done_d = 1'b1;
            if (!store_q) rdata_d = load_extend({32'b0, bus_rdata}, off_q, size_q, uns_q);
          end
        end
      end
      BEAT1: begin
        if (bus_ready) begin
          {bus_req_d, bus_we_d, bus_addr_d, bus_be_d, bus_wdata_d} = '0;
          done_d = 1'b1;
          if (!store_q) rdata_d = load_extend({bus_rdata, lo_q}, off_q, size_q, uns_q);
        end
      end
      default: ;
    endcase
  end

  assign busy = rst_n && ((state_q == BEAT0) || (state_q == BEAT1) ||
                          (state_q == IDLE && req_valid));

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: directed test-plan steps followed by random accesses,
// all checked against a byte-level model of lanes, beats and load extension.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = '0;

  lsu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access byte k sits at global lane o+k; beat b carries global lanes 4b..4b+3.
  function automatic void exp_beat(input int b, input logic [31:0] a, input int n,
                                   input logic [31:0] wd, output logic [31:0] ea,
                                   output logic [3:0] ebe, output logic [31:0] ewd);
    int o, k;
    o   = int'(a[1:0]);
    ea  = {a[31:2], 2'b00} + 32'(4 * b);
    ebe = '0;
    ewd = '0;
    for (int l = 0; l < 4; l++) begin
      k = 4 * b + l - o;
      if (k >= 0 && k < n) begin
        ebe[l] = 1'b1;
        ewd[8*l +: 8] = wd[8*k +: 8];
      end
    end
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input int n, input logic uns,
                                           input logic [31:0] r0, input logic [31:0] r1);
    logic [31:0] v, beat;
    int o, p;
    v = '0;
    o = int'(a[1:0]);
    for (int k = 0; k < n; k++) begin
      p = o + k;
      beat = (p < 4) ? r0 : r1;
      v[8*k +: 8] = beat[8*(p % 4) +: 8];
    end
    if (!uns && n < 4 && v[8*n-1]) begin
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int w0, input int w1,
                        input logic [31:0] r0, input logic [31:0] r1);
    int n, nb;
    int waits [2];
    logic [31:0] ea, ewd;
    logic [3:0]  ebe;
    waits[0] = w0;
    waits[1] = w1;
    start = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    addr = a; wdata = wd; bus_ready = 1'b0;
    #1 check("busy_on_start", busy, 32'(rd | wr));
    @(negedge clk);
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if (!(rd | wr)) begin
      check("ignored_no_req", bus_req, 0);
      check("ignored_no_done", done, 0);
      return;
    end
    if (sz == 2'b11) begin
      last_rdata = '0;
      check("illegal_done", done, 1);
      check("illegal_err", err, 1);
      check("illegal_no_req", bus_req, 0);
      check("illegal_busy", busy, 0);
    end else begin
      n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      nb = (int'(a[1:0]) + n > 4) ? 2 : 1;
      for (int b = 0; b < nb; b++) begin
        exp_beat(b, a, n, wd, ea, ebe, ewd);
        for (int w = 0; w <= waits[b]; w++) begin
          check("beat_req", bus_req, 1);
          check("beat_we", bus_we, 32'(wr));
          check("beat_addr", bus_addr, ea);
          check("beat_be", 32'(bus_be), 32'(ebe));
          check("beat_wdata", bus_wdata, ewd);
          check("beat_busy", busy, 1);
          check("beat_no_done", done, 0);
          bus_ready = (w == waits[b]);
          bus_rdata = (b == 0) ? r0 : r1;
          @(negedge clk);
        end
      end
      bus_ready = 1'b0;
      bus_rdata = $urandom;
      if (!wr) last_rdata = exp_load(a, n, uns, r0, r1);
      check("done_pulse", done, 1);
      check("done_err", err, 0);
      check("done_busy", busy, 0);
      check("done_req_drop", bus_req, 0);
    end
    check("rdata", rdata, last_rdata);
    @(negedge clk);
    check("idle_done_low", done, 0);
    check("idle_err_low", err, 0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_req", bus_req, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", 32'(bus_be), 0);
    check("rst_wdata", bus_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0);
    check("lw_value", rdata, 32'hDEADBEEF);
    access(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 0, 0, 32'h80123456, 32'h0);
    check("lb_value", rdata, 32'hFFFFFF80);
    access(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 0, 0, 32'h80123456, 32'h0);
    check("lbu_value", rdata, 32'h00000080);
    access(0, 1, 2'b01, 0, 32'h0000_0102, 32'h1234ABCD, 0, 0, 32'h0, 32'h0);
    check("sh_keeps_rdata", rdata, 32'h00000080);
    access(1, 0, 2'b10, 0, 32'h0000_0105, 32'h0, 0, 0, 32'h44332211, 32'h88776655);
    check("split_lw_value", rdata, 32'h55443322);
    access(0, 1, 2'b10, 0, 32'hFFFF_FFFE, 32'hAABBCCDD, 2, 2, 32'h0, 32'h0);
    access(1, 0, 2'b11, 0, 32'h0000_0200, 32'h0, 0, 0, 32'h0, 32'h0);
    check("illegal_rdata_zero", rdata, 0);
    access(0, 0, 2'b10, 0, 32'h0000_0300, 32'h0, 0, 0, 32'h0, 32'h0);
    access(1, 1, 2'b01, 1, 32'h0000_0403, 32'hCAFE1234, 1, 0, 32'h0, 32'h0);
    access(1, 0, 2'b01, 1, 32'h0000_0403, 32'h0, 0, 1, 32'h11000000, 32'h00000022);
    check("split_lhu_value", rdata, 32'h00002211);

    // Reset while the second beat of a split load is outstanding.
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    addr = 32'h0000_0105;
    @(negedge clk);
    start = 1'b0; mem_read = 1'b0;
    bus_ready = 1'b1; bus_rdata = 32'h44332211;
    @(negedge clk);
    bus_ready = 1'b0;
    check("pre_rst_beat1_addr", bus_addr, 32'h0000_0108);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_be", 32'(bus_be), 0);
    check("mid_rst_rdata", rdata, 0);
    last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 0, 0, 32'h0BADF00D, 32'h0);
    check("post_rst_lw", rdata, 32'h0BADF00D);

    for (int i = 0; i < 200; i++) begin
      int op;
      logic rd, wr, uns;
      logic [1:0] sz;
      logic [31:0] a;
      op  = int'($urandom_range(0, 19));
      rd  = (op == 0) ? 1'b0 : (op == 1) ? 1'b1 : (op < 11);
      wr  = (op == 0) ? 1'b0 : (op == 1) ? 1'b1 : (op >= 11);
      sz  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      access(rd, wr, sz, uns, a, $urandom, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Multi-cycle load/store sequencer between the core's memory stage and a 32-bit word-addressed data bus. It takes the memory control fields produced by instruction decode (`mem_read`, `mem_write`, `mem_size`, `mem_unsigned`) together with the effective address and store data. It then drives one or two handshaked bus transfers, with byte enables and lane shifting, and returns sign- or zero-extended load data. It stalls the pipeline until the access completes and splits misaligned accesses that cross a word boundary into two beats.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: memory-stage instruction valid with `mem_read` or `mem_write` set; sampled only in IDLE.
- `mem_read` in 1: load.
- `mem_write` in 1: store.
- `mem_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `mem_unsigned` in 1: 1 zero-extends the load, 0 sign-extends it.
- `addr` in 32: effective byte address.
- `wdata` in 32: store data, right-justified.
- `busy` out 1: pipeline stall request.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse with `done` for an illegal request.
- `rdata` out 32: extended load result.
- `bus_req` out 1: transfer request.
- `bus_we` out 1: write transfer.
- `bus_addr` out 32: word-aligned address; bits [1:0] are always 0.
- `bus_be` out 4: byte-lane enables; bit i enables bits [8i+7:8i].
- `bus_wdata` out 32: lane-positioned store data.
- `bus_ready` in 1: transfer accepted or complete at this edge.
- `bus_rdata` in 32: read data, valid when `bus_ready`=1.

## Operation
- **States:** IDLE, BEAT0, BEAT1, DONE.
- **IDLE:** `start`=1 with neither `mem_read` nor `mem_write` set is ignored. When `mem_write`=1, the access is a store; this takes priority if both are set.
  - `mem_size`=11 goes to DONE with `err`=1, no bus transfer, and `rdata` set to 0.
  - Otherwise, latch the request and go to BEAT0.
- **Byte count:** n = 1, 2 or 4; offset o = `addr`[1:0]. The access is split when o+n > 4.
- **BEAT0:**
  - `bus_addr` = {`addr`[31:2], 2'b00}.
  - `bus_be` covers lanes o to min(o+n,4)-1.
  - `bus_wdata` = low word of ({32'b0, `wdata`} << 8o); unused lanes carry don't-care, driven to 0.
  - On `bus_ready`: go to BEAT1 if split, else DONE.
- **BEAT1:**
  - `bus_addr` = BEAT0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - `bus_be` covers lanes 0 to o+n-5.
  - `bus_wdata` = high word of the same shift.
  - On `bus_ready`: go to DONE.
- **Loads:** beat read data is captured into a 64-bit buffer {beat1, beat0}. The result is (buffer >> 8o) truncated to n bytes, then extended per `mem_unsigned`. Word loads ignore `mem_unsigned`.
- **DONE:** `done`=1 and `rdata` updated for loads; stores leave `rdata` unchanged. Always returns to IDLE next cycle. `start` is not sampled in DONE.
- **`busy`:** combinational; 1 when (IDLE & accepted `start`) or in BEAT0 or BEAT1; 0 in DONE. The pipeline therefore advances in the DONE cycle.
- **Reset:** asynchronous and immediate from any state, including mid-transfer.
  - All registered outputs reset to 0: `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `done`, `err`, `rdata`.
  - State returns to IDLE; `busy` is forced to 0 while `rst_n`=0.
  - Any in-flight bus transfer is abandoned; the bus must tolerate request withdrawal on reset.

## Timing
- All bus outputs are registered.
- **Handshake:** `bus_req`, `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` remain stable from assertion until the edge where `bus_ready`=1.
- `bus_ready` is ignored while `bus_req`=0.
- `bus_req` stays high across BEAT0→BEAT1, with new address, enables and data from the cycle after the first acceptance.
- **Latency** (`start` sampled at edge 0, `bus_ready` tied high):
  - `bus_req`=1 in cycle 1.
  - Aligned access: `done` in cycle 2.
  - Split access: `done` in cycle 3.
  - Each wait cycle (`bus_ready`=0) adds one cycle.
  - Illegal request: `done` and `err` in cycle 1.
- **Back-to-back:** the next `start` is accepted in the IDLE cycle after DONE, so the minimum issue interval is 3 cycles.
- `rdata` holds its value until the next load completes.

## Test plan
- **Aligned LW, zero wait:** LW `addr`=0x100, `bus_ready`=1, `bus_rdata`=0xDEADBEEF → cycle 1: `bus_addr`=0x100, `bus_be`=1111, `bus_we`=0; cycle 2: `done`=1, `rdata`=0xDEADBEEF, `busy`=0.
- **LB vs LBU:** `addr`=0x103, `bus_rdata`=0x80123456 → `bus_be`=1000; LB gives `rdata`=0xFFFFFF80, LBU gives 0x00000080.
- **Aligned SH:** `addr`=0x102, `wdata`=0x1234ABCD → `bus_we`=1, `bus_be`=1100, `bus_wdata`[31:16]=0xABCD, single beat, `done` in cycle 2.
- **Split LW:** `addr`=0x105; beat0 0x104 returns 0x44332211, beat1 0x108 returns 0x88776655 → beat0 `bus_be`=1110, beat1 `bus_be`=0001, `done` in cycle 3, `rdata`=0x55443322.
- **Wait states and wrap:** SW `addr`=0xFFFFFFFE, `wdata`=0xAABBCCDD, `bus_ready` low 2 cycles on each beat →
  - Beat0: 0xFFFFFFFC, `be`=1100, `wdata`=0xCCDD0000, held stable while waiting.
  - Beat1: 0x00000000, `be`=0011, `wdata`=0x0000AABB.
  - `done` in cycle 7.
- **Illegal size and reset:**
  - `mem_size`=11 → no `bus_req`; `done`=`err`=1 in cycle 1; `rdata`=0.
  - Separately, `rst_n` low during BEAT1 → `bus_req`=0 and `busy`=0 immediately. A subsequent aligned LW completes normally in 2 cycles.
